// File: rtl/adder_exhaustive_checker.sv
// adder_exhaustive_checker
//
// Exhaustive test engine for a 4-bit ripple-carry adder. Walks all 512
// combinations of {a, b, cin}, waits SETTLE cycles per vector, then compares
// the adder response against a golden a+b+cin. Reports the error count, the
// first failing vector and a pass/done status.
//
// Parameters:
//   SETTLE       cycles between driving a vector and sampling it (1..255)
//   STOP_ON_FAIL 1 = finish on first mismatch, 0 = run all 512 vectors
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        level; begins a run when idle or done, ignored while busy
//   dut_a/b/cin  stimulus to the adder, direct bits of the vector register
//   dut_sum/cout response from the adder
//   busy         run in progress (WAIT or CHECK)
//   done         run finished, results held
//   pass         done with zero mismatches
//   err_count    number of mismatching vectors (0..512)
//   fail_valid   a mismatch has been recorded this run
//   fail_vec     {a,b,cin} of the first mismatch, 0 when fail_valid=0
//   state_dbg    current FSM state encoding, for observation only
//
// start is a plain level with no handshake: it is acted on only in the
// cycle where the FSM is in IDLE or DONE, and has no effect otherwise.

module adder_exhaustive_checker #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic       fail_valid,
    output logic [8:0] fail_vec,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [8:0] VEC_LAST    = 9'h1FF;

    state_t     state, state_nxt;
    logic [8:0] vec, vec_nxt;
    logic [7:0] settle_cnt, settle_cnt_nxt;
    logic [9:0] err_count_nxt;
    logic       fail_valid_nxt;
    logic [8:0] fail_vec_nxt;

    logic [4:0] golden;
    logic       mismatch;

    // Full 5-bit golden result so a missing carry-out is caught too.
    assign golden   = {1'b0, vec[8:5]} + {1'b0, vec[4:1]} + {4'b0000, vec[0]};
    assign mismatch = (golden != {dut_cout, dut_sum});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vec        <= 9'd0;
            settle_cnt <= 8'd0;
            err_count  <= 10'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 9'd0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_cnt_nxt;
            err_count  <= err_count_nxt;
            fail_valid <= fail_valid_nxt;
            fail_vec   <= fail_vec_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        settle_cnt_nxt = settle_cnt;
        err_count_nxt  = err_count;
        fail_valid_nxt = fail_valid;
        fail_vec_nxt   = fail_vec;

        case (state)
            S_IDLE, S_DONE: begin
                // Results are cleared on the same edge the run starts.
                if (start) begin
                    state_nxt      = S_WAIT;
                    vec_nxt        = 9'd0;
                    settle_cnt_nxt = 8'd0;
                    err_count_nxt  = 10'd0;
                    fail_valid_nxt = 1'b0;
                    fail_vec_nxt   = 9'd0;
                end
            end
            S_WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_count_nxt = err_count + 10'd1;
                    if (!fail_valid) begin
                        fail_valid_nxt = 1'b1;
                        fail_vec_nxt   = vec;
                    end
                end
                // vec stays at its last value in DONE; it never wraps.
                if ((mismatch && STOP_ON_FAIL) || (vec == VEC_LAST)) begin
                    state_nxt = S_DONE;
                end else begin
                    vec_nxt        = vec + 9'd1;
                    settle_cnt_nxt = 8'd0;
                    state_nxt      = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dut_a     = vec[8:5];
    assign dut_b     = vec[4:1];
    assign dut_cin   = vec[0];
    assign busy      = (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_count == 10'd0);
    assign state_dbg = state;

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
module tb_adder_exhaustive_checker;

  localparam int W = 37;  // {pass, err_count[9:0], fail_valid, fail_vec[8:0], latency[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- three instances, one per parameter set ----------------
  // 0: SETTLE=1 STOP_ON_FAIL=0   1: SETTLE=1 STOP_ON_FAIL=1   2: SETTLE=3 STOP_ON_FAIL=0
  logic       start_w [3];
  logic [3:0] a_w     [3];
  logic [3:0] b_w     [3];
  logic       cin_w   [3];
  logic [3:0] sum_w   [3];
  logic       cout_w  [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [9:0] err_w   [3];
  logic       fv_w    [3];
  logic [8:0] fvec_w  [3];
  logic [1:0] st_w    [3];
  int         fmode   [3];  // 0 good adder, 1 b[3] stuck 0, 2 cout stuck 0 at vector 1FF

  // Adder model with optional fault.
  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input int mode);
    logic [3:0] bb;
    logic [4:0] r;
    bb = b;
    if (mode == 1) bb[3] = 1'b0;
    r = {1'b0, a} + {1'b0, bb} + {4'b0000, c};
    if (mode == 2 && {a, b, c} == 9'h1FF) r[4] = 1'b0;
    return r;
  endfunction

  assign {cout_w[0], sum_w[0]} = adder_model(a_w[0], b_w[0], cin_w[0], fmode[0]);
  assign {cout_w[1], sum_w[1]} = adder_model(a_w[1], b_w[1], cin_w[1], fmode[1]);
  assign {cout_w[2], sum_w[2]} = adder_model(a_w[2], b_w[2], cin_w[2], fmode[2]);

  adder_exhaustive_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_w[0]),
    .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_cin(cin_w[0]),
    .dut_sum(sum_w[0]), .dut_cout(cout_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_valid(fv_w[0]), .fail_vec(fvec_w[0]), .state_dbg(st_w[0])
  );

  adder_exhaustive_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_w[1]),
    .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_cin(cin_w[1]),
    .dut_sum(sum_w[1]), .dut_cout(cout_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_valid(fv_w[1]), .fail_vec(fvec_w[1]), .state_dbg(st_w[1])
  );

  adder_exhaustive_checker #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start_w[2]),
    .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_cin(cin_w[2]),
    .dut_sum(sum_w[2]), .dut_cout(cout_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
    .fail_valid(fv_w[2]), .fail_vec(fvec_w[2]), .state_dbg(st_w[2])
  );

  // ---------------- selected-instance view ----------------
  int         sel = 0;
  logic       m_done, m_pass, m_fv, m_busy;
  logic [9:0] m_err;
  logic [8:0] m_fvec, m_vec;

  always_comb begin
    m_done = done_w[sel];
    m_pass = pass_w[sel];
    m_fv   = fv_w[sel];
    m_busy = busy_w[sel];
    m_err  = err_w[sel];
    m_fvec = fvec_w[sel];
    m_vec  = {a_w[sel], b_w[sel], cin_w[sel]};
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int e0    = 0;
  logic m_done_q = 1'b0;

  function automatic logic [W-1:0] pack_res(input logic p, input logic [9:0] e, input logic fv,
                                            input logic [8:0] fvec, input int lat);
    logic [15:0] l;
    l = lat[15:0];
    return {p, e, fv, fvec, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: a run result is presented on the rising edge of done.
  always @(negedge clk) begin
    logic [W-1:0] act, expv;
    if (m_done && !m_done_q) begin
      act = pack_res(m_pass, m_err, m_fv, m_fvec, cyc - e0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected actual=%0h expected=none", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          bad++;
          $display("FAIL result actual pass=%0d err=%0d fv=%0d fvec=%0h lat=%0d expected pass=%0d err=%0d fv=%0d fvec=%0h lat=%0d",
                   act[36], act[35:26], act[25], act[24:16], act[15:0],
                   expv[36], expv[35:26], expv[25], expv[24:16], expv[15:0]);
        end
      end
    end
    m_done_q <= m_done;
  end

  // Sequence watcher: while enabled, every vector change must be +1.
  logic       seq_en = 1'b0;
  logic [8:0] seq_last = 9'd0;
  int         seq_steps = 0;
  int         seq_err = 0;
  always @(negedge clk) begin
    if (seq_en && m_vec != seq_last) begin
      if (m_vec != seq_last + 9'd1) seq_err <= seq_err + 1;
      seq_steps <= seq_steps + 1;
      seq_last  <= m_vec;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_start(input int idx, input bit push, input logic [W-1:0] expv);
    @(negedge clk);
    sel = idx;
    if (push) exp_q.push_back(expv);
    start_w[idx] = 1'b1;
    @(posedge clk);  // edge E0
    @(negedge clk);
    e0 = cyc;
    start_w[idx] = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    for (i = 0; i < limit && !m_done; i++) @(negedge clk);
    if (!m_done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=not_done expected=done", name);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {8'd0, a_w[0], b_w[0], cin_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fv_w[0], fvec_w[0]}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      fmode[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    // Good adder, full walk, vectors in order.
    fmode[0] = 0;
    seq_last = 9'd0;
    seq_en   = 1'b1;
    run_start(0, 1'b1, pack_res(1'b1, 10'd0, 1'b0, 9'h000, 1024));
    wait_done("good_run", 1100);
    seq_en = 1'b0;
    check("seq_order_errors", seq_err, 0);
    check("seq_step_count", seq_steps, 511);
    check("final_vec", {23'd0, m_vec}, 32'h1FF);

    // b[3] stuck at 0, run everything.
    fmode[0] = 1;
    run_start(0, 1'b1, pack_res(1'b0, 10'd256, 1'b1, 9'h010, 1024));
    wait_done("b3_run", 1100);

    // Restart from DONE holding err_count=256: results clear on the start edge.
    run_start(0, 1'b1, pack_res(1'b0, 10'd256, 1'b1, 9'h010, 1024));
    check("restart_busy", {31'd0, m_busy}, 32'd1);
    check("restart_cleared", {12'd0, m_err, m_fv, m_fvec}, 32'd0);
    wait_done("restart_run", 1100);

    // Same fault, stop on first failure.
    fmode[1] = 1;
    run_start(1, 1'b1, pack_res(1'b0, 10'd1, 1'b1, 9'h010, 34));
    wait_done("stop_run", 100);
    check("stop_vec_held", {23'd0, m_vec}, 32'h010);

    // SETTLE=3, single-sample cout fault at 1FF, start pulsed while busy.
    fmode[2] = 2;
    run_start(2, 1'b1, pack_res(1'b0, 10'd1, 1'b1, 9'h1FF, 2048));
    repeat (500) @(negedge clk);
    start_w[2] = 1'b1;
    repeat (3) @(negedge clk);
    start_w[2] = 1'b0;
    check("still_busy_after_start", {31'd0, m_busy}, 32'd1);
    wait_done("settle3_run", 2100);

    // Mid-run asynchronous reset at vector 100, then a clean run.
    fmode[0] = 0;
    run_start(0, 1'b0, '0);
    for (int i = 0; i < 400 && m_vec != 9'd100; i++) @(negedge clk);
    check("reached_vec100", {23'd0, m_vec}, 32'd100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    run_start(0, 1'b1, pack_res(1'b1, 10'd0, 1'b0, 9'h000, 1024));
    check("post_reset_vec0", {23'd0, m_vec}, 32'd0);
    wait_done("post_reset_run", 1100);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_exhaustive_checker.md
# adder_exhaustive_checker

Self-checking exhaustive test engine for the 4-bit ripple-carry adder. It drives all 512 combinations of {a, b, cin} into the adder under test. After each vector it waits a programmable settle time, then samples the adder's sum/cout against a golden a+b+cin. It reports an error count, the first failing vector and a pass/done status. It sits directly upstream of the adder (stimulus) and downstream of it (response capture) on the lab board.

## Interface
- SETTLE, 1: cycles between driving a vector and sampling the response; legal range 1..255.
- STOP_ON_FAIL, 0: 1 = finish on first mismatch; 0 = run all 512 vectors.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each cycle; begins a run when in IDLE or DONE.
- dut_a  out  4  adder operand a = vec[8:5].
- dut_b  out  4  adder operand b = vec[4:1].
- dut_cin  out  1  adder carry-in = vec[0].
- dut_sum  in  4  adder sum.
- dut_cout  in  1  adder carry-out.
- busy  out  1  high in WAIT/CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  10  number of mismatching vectors, 0..512.
- fail_valid  out  1  a mismatch has been recorded this run.
- fail_vec  out  9  {a,b,cin} of first mismatch; 0 when fail_valid=0.

## Operation
- Registers: vec[8:0], settle_cnt[7:0], state, err_count, fail_valid, fail_vec. dut_* are direct bits of vec (no combinational logic).
- Golden: exp[4:0] = {1'b0,a} + {1'b0,b} + cin (5-bit, no truncation). Compare against {dut_cout, dut_sum}.
- States:
  - IDLE: start=1 -> WAIT.
  - WAIT: when settle_cnt==SETTLE-1 -> CHECK; else settle_cnt++.
  - CHECK: compare. On mismatch: err_count++; if !fail_valid, set fail_valid=1 and fail_vec=vec. Then:
    - if (mismatch && STOP_ON_FAIL) or vec==511 -> DONE;
    - else vec++, settle_cnt=0, -> WAIT.
  - DONE: holds all results; start=1 -> WAIT.
- On a start transition (IDLE/DONE -> WAIT): vec=0, settle_cnt=0, err_count=0, fail_valid=0, fail_vec=0.
- start while busy is ignored; no effect on vec or results.
- vec never wraps within a run; 511 is terminal.
- err_count cannot overflow: 10 bits hold 512.

## Timing
- Reset (async, immediate): state=IDLE; vec=0 (dut_a=0, dut_b=0, dut_cin=0); busy=0; done=0; pass=0; err_count=0; fail_valid=0; fail_vec=0.
- Reset mid-run aborts immediately to the reset values. No partial results are retained.
- A vector is driven from the edge that enters WAIT. It is sampled in CHECK, which is SETTLE cycles later. Each vector occupies SETTLE+1 cycles.
- Full run: start sampled at edge E0 -> done=1 after edge E0 + 512*(SETTLE+1). busy falls on the same edge.
- STOP_ON_FAIL run failing at vector k: done after E0 + (k+1)*(SETTLE+1).
- err_count, fail_valid and fail_vec update on the edge leaving CHECK. pass is valid only while done=1.
- Simultaneous start and DONE entry: start is not seen until the following cycle (state is CHECK, not DONE).

## Test plan
- Correct adder model, SETTLE=1, start pulse -> exactly 1024 cycles later done=1, pass=1, err_count=0, fail_valid=0. dut_* step through 0..511 in order.
- Faulty adder with bit-3 b input forced to 0, STOP_ON_FAIL=0 -> err_count=256, fail_valid=1, fail_vec=9'h010 (a=0, b=8, cin=0), pass=0.
- Same faulty adder, STOP_ON_FAIL=1, SETTLE=1 -> done after 34 cycles, err_count=1, fail_vec=9'h010, vec holds 9'h010.
- SETTLE=3, correct adder; start re-asserted while busy, and a stuck-at-0 dut_cout injected for one sample only when vec=9'h1FF -> start ignored; done at 2048 cycles; err_count=1, fail_vec=9'h1FF.
- rst asserted asynchronously mid-cycle at vec=100 -> all outputs return to reset values immediately. A new start then runs from vec=0 with err_count cleared.
- From DONE with err_count=256, assert start -> results cleared on the same edge, busy=1, and a fresh run completes with consistent counts.
